systolic_tile_scheduler: RTL

- Top-level sequencer for systolic_system. Takes a matrix job (M,K,N) and tiles it onto the ARRAY_N x ARRAY_M array.
- Per tile, drives the A/W buffer read enables, base addresses and row/col counts, the array operation code, and O-buffer accumulate/drain controls.
- Sits between the AXI-lite register block and systolic_system. Handshake is start/busy/done.

---
 rtl/systolic_tile_scheduler_if.sv | 59 +++++
 rtl/systolic_tile_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_scheduler_if.sv
// Job handshake and per-tile control bundle between the register block
// (master) and the tile scheduler (slave).
// Optional macro: SCHED_PERF_CNT_EN adds cycle_count / tile_count.
interface systolic_tile_scheduler_if #(
  parameter int ARRAY_N    = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DIM_WIDTH  = 16
);
  localparam int NUM_W = $clog2(ARRAY_N) + 1;

  logic                  start;
  logic [DIM_WIDTH-1:0]  M;
  logic [DIM_WIDTH-1:0]  K;
  logic [DIM_WIDTH-1:0]  N;
  logic                  busy;
  logic                  done;
  logic                  a_buf_on;
  logic [ADDR_WIDTH-1:0] a_base_addr;
  logic [NUM_W-1:0]      a_num_rows;
  logic                  w_buf_on;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] w_base_addr;
  logic [NUM_W-1:0]      w_num_cols;
  logic [2:0]            operation_signal;
  logic                  o_idx_gen_on;
  logic                  o_ag_o_on;
  logic                  o_drain;
  logic [ADDR_WIDTH-1:0] o_base_addr;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]           cycle_count;
  logic [15:0]           tile_count;

  modport master (
    output start, M, K, N,
    input  busy, done, a_buf_on, a_base_addr, a_num_rows, w_buf_on, mode,
           w_base_addr, w_num_cols, operation_signal, o_idx_gen_on,
           o_ag_o_on, o_drain, o_base_addr, cycle_count, tile_count
  );
  modport slave (
    input  start, M, K, N,
    output busy, done, a_buf_on, a_base_addr, a_num_rows, w_buf_on, mode,
           w_base_addr, w_num_cols, operation_signal, o_idx_gen_on,
           o_ag_o_on, o_drain, o_base_addr, cycle_count, tile_count
  );
`else
  modport master (
    output start, M, K, N,
    input  busy, done, a_buf_on, a_base_addr, a_num_rows, w_buf_on, mode,
           w_base_addr, w_num_cols, operation_signal, o_idx_gen_on,
           o_ag_o_on, o_drain, o_base_addr
  );
  modport slave (
    input  start, M, K, N,
    output busy, done, a_buf_on, a_base_addr, a_num_rows, w_buf_on, mode,
           w_base_addr, w_num_cols, operation_signal, o_idx_gen_on,
           o_ag_o_on, o_drain, o_base_addr
  );
`endif
endinterface

// File: rtl/systolic_tile_scheduler.sv
// Tile sequencer: walks an (M,K,N) job over the ARRAY_N x ARRAY_M array in
// n/m/k loop order, driving LOAD_W, COMPUTE and DRAIN phases per tile.
// Every output is registered from the current state, so each phase's
// enables appear one cycle after the state is entered.
// Optional macro: SCHED_PERF_CNT_EN adds busy-cycle and tile counters.
module systolic_tile_scheduler #(
  parameter int ARRAY_N    = 8,
  parameter int ARRAY_M    = 8,
  parameter int RAM_SIZE   = 256,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DIM_WIDTH  = 16
) (
  input  logic clk,
  input  logic reset,
  systolic_tile_scheduler_if.slave sched_if
);
  localparam int NUM_W = $clog2(ARRAY_N) + 1;
  localparam int CNT_W = $clog2(2 * ARRAY_N + ARRAY_M);

  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_LOAD_W, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t                r_state, w_state_next;
  logic [DIM_WIDTH-1:0]  r_m, r_n, r_mt, r_kt, r_nt, r_mi, r_ki, r_ni;
  logic [CNT_W-1:0]      r_cnt;

  logic                  r_busy, r_done, r_a_buf_on, r_w_buf_on, r_mode;
  logic                  r_idx_on, r_ag_on, r_drain;
  logic [ADDR_WIDTH-1:0] r_a_base, r_w_base, r_o_base;
  logic [NUM_W-1:0]      r_rows, r_cols;
  logic [2:0]            r_op;

  logic                  w_busy, w_done, w_a_buf_on, w_w_buf_on, w_mode;
  logic                  w_idx_on, w_ag_on, w_drain;
  logic [ADDR_WIDTH-1:0] w_a_base, w_w_base, w_o_base;
  logic [NUM_W-1:0]      w_rows, w_cols;
  logic [2:0]            w_op;

  // A start coinciding with the done pulse is dropped so the handshake
  // always shows one idle cycle between jobs.
  logic w_accept, w_dims_zero;
  assign w_accept    = (r_state == S_IDLE) && sched_if.start && !r_done;
  assign w_dims_zero = (sched_if.M == '0) || (sched_if.K == '0) || (sched_if.N == '0);

  // Remaining rows/columns of the current tile, clipped to the array size.
  logic [31:0] w_m_rem, w_n_rem;
  assign w_m_rem = 32'(r_m) - 32'(r_mi) * 32'(ARRAY_N);
  assign w_n_rem = 32'(r_n) - 32'(r_ni) * 32'(ARRAY_M);
  assign w_rows  = (w_m_rem > 32'(ARRAY_N)) ? NUM_W'(ARRAY_N) : NUM_W'(w_m_rem);
  assign w_cols  = (w_n_rem > 32'(ARRAY_M)) ? NUM_W'(ARRAY_M) : NUM_W'(w_n_rem);

  // Tile bases in units of ARRAY_N entries; wrap silently at RAM_SIZE.
  assign w_a_base = ADDR_WIDTH'(((32'(r_mi) * 32'(r_kt) + 32'(r_ki)) * 32'(ARRAY_N)) % 32'(RAM_SIZE));
  assign w_w_base = ADDR_WIDTH'(((32'(r_ni) * 32'(r_kt) + 32'(r_ki)) * 32'(ARRAY_N)) % 32'(RAM_SIZE));
  assign w_o_base = ADDR_WIDTH'(((32'(r_ni) * 32'(r_mt) + 32'(r_mi)) * 32'(ARRAY_N)) % 32'(RAM_SIZE));

  // Phase-end and loop-continuation conditions.
  logic w_load_last, w_cmp_last, w_drain_last, w_k_more, w_m_more, w_n_more;
  assign w_load_last  = 32'(r_cnt) == 32'(ARRAY_N - 1);
  assign w_cmp_last   = 32'(r_cnt) == 32'(w_rows) + 32'(ARRAY_N + ARRAY_M - 2);
  assign w_drain_last = 32'(r_cnt) == 32'(ARRAY_M - 1);
  assign w_k_more     = 32'(r_ki) + 32'd1 < 32'(r_kt);
  assign w_m_more     = 32'(r_mi) + 32'd1 < 32'(r_mt);
  assign w_n_more     = 32'(r_ni) + 32'd1 < 32'(r_nt);

  // State register plus job registers, tile indices and phase counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_m  <= '0; r_n  <= '0;
      r_mt <= '0; r_kt <= '0; r_nt <= '0;
      r_mi <= '0; r_ki <= '0; r_ni <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_m  <= sched_if.M;
        r_n  <= sched_if.N;
        r_mt <= DIM_WIDTH'((32'(sched_if.M) + 32'(ARRAY_N - 1)) / 32'(ARRAY_N));
        r_kt <= DIM_WIDTH'((32'(sched_if.K) + 32'(ARRAY_N - 1)) / 32'(ARRAY_N));
        r_nt <= DIM_WIDTH'((32'(sched_if.N) + 32'(ARRAY_M - 1)) / 32'(ARRAY_M));
        r_mi <= '0; r_ki <= '0; r_ni <= '0;
        r_cnt <= '0;
      end else begin
        case (r_state)
          S_LOAD_W: r_cnt <= w_load_last ? '0 : r_cnt + 1'b1;
          S_COMPUTE: begin
            if (w_cmp_last) begin
              r_cnt <= '0;
              if (w_k_more) r_ki <= r_ki + 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DRAIN: begin
            if (w_drain_last) begin
              r_cnt <= '0;
              r_ki  <= '0;
              if (w_m_more) begin
                r_mi <= r_mi + 1'b1;
              end else begin
                r_mi <= '0;
                r_ni <= w_n_more ? r_ni + 1'b1 : '0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = w_dims_zero ? S_ZERO : S_LOAD_W;
      S_ZERO:    w_state_next = S_IDLE;
      S_LOAD_W:  if (w_load_last) w_state_next = S_COMPUTE;
      S_COMPUTE: if (w_cmp_last) w_state_next = w_k_more ? S_LOAD_W : S_DRAIN;
      S_DRAIN:   if (w_drain_last) w_state_next = (w_m_more || w_n_more) ? S_LOAD_W : S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    w_busy = w_accept; w_done = 1'b0;
    w_a_buf_on = 1'b0; w_w_buf_on = 1'b0; w_mode = 1'b0;
    w_idx_on = 1'b0; w_ag_on = 1'b0; w_drain = 1'b0; w_op = 3'b000;
    case (r_state)
      S_LOAD_W: begin
        w_busy = 1'b1; w_w_buf_on = 1'b1; w_op = 3'b001;
      end
      S_COMPUTE: begin
        w_busy = 1'b1; w_mode = 1'b1; w_op = 3'b010; w_idx_on = 1'b1;
        w_a_buf_on = 32'(r_cnt) < 32'(w_rows);
      end
      S_DRAIN: begin
        w_busy = 1'b1; w_drain = 1'b1; w_ag_on = 1'b1; w_op = 3'b100;
      end
      S_ZERO, S_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // Output registers; tile geometry is only presented while a tile is active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0; r_done <= 1'b0;
      r_a_buf_on <= 1'b0; r_w_buf_on <= 1'b0; r_mode <= 1'b0;
      r_idx_on <= 1'b0; r_ag_on <= 1'b0; r_drain <= 1'b0; r_op <= 3'b000;
      r_a_base <= '0; r_w_base <= '0; r_o_base <= '0;
      r_rows <= '0; r_cols <= '0;
    end else begin
      r_busy <= w_busy; r_done <= w_done;
      r_a_buf_on <= w_a_buf_on; r_w_buf_on <= w_w_buf_on; r_mode <= w_mode;
      r_idx_on <= w_idx_on; r_ag_on <= w_ag_on; r_drain <= w_drain; r_op <= w_op;
      if (r_state == S_LOAD_W || r_state == S_COMPUTE || r_state == S_DRAIN) begin
        r_a_base <= w_a_base; r_w_base <= w_w_base; r_o_base <= w_o_base;
        r_rows <= w_rows; r_cols <= w_cols;
      end else begin
        r_a_base <= '0; r_w_base <= '0; r_o_base <= '0;
        r_rows <= '0; r_cols <= '0;
      end
    end
  end

  assign sched_if.busy             = r_busy;
  assign sched_if.done             = r_done;
  assign sched_if.a_buf_on         = r_a_buf_on;
  assign sched_if.a_base_addr      = r_a_base;
  assign sched_if.a_num_rows       = r_rows;
  assign sched_if.w_buf_on         = r_w_buf_on;
  assign sched_if.mode             = r_mode;
  assign sched_if.w_base_addr      = r_w_base;
  assign sched_if.w_num_cols       = r_cols;
  assign sched_if.operation_signal = r_op;
  assign sched_if.o_idx_gen_on     = r_idx_on;
  assign sched_if.o_ag_o_on        = r_ag_on;
  assign sched_if.o_drain          = r_drain;
  assign sched_if.o_base_addr      = r_o_base;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_cycle_count;
  logic [15:0] r_tile_count;

  // Busy-cycle (saturating) and completed-tile counters, cleared per job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= '0;
      r_tile_count  <= '0;
    end else if (w_accept) begin
      r_cycle_count <= '0;
      r_tile_count  <= '0;
    end else begin
      if (r_busy && r_cycle_count != 32'hFFFF_FFFF) r_cycle_count <= r_cycle_count + 1'b1;
      if (r_state == S_DRAIN && w_drain_last) r_tile_count <= r_tile_count + 1'b1;
    end
  end

  assign sched_if.cycle_count = r_cycle_count;
  assign sched_if.tile_count  = r_tile_count;
`endif
endmodule
